// File: rtl/mfp_ahb_uart_tx.sv
// rtl/mfp_ahb_uart_tx.sv - AHB-Lite UART transmitter with TX FIFO (optional parity: MFP_UART_TX_PARITY_EN)
module mfp_ahb_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        TX_BUSY
);
    localparam int                 LP_DEPTH    = 2 ** FIFO_AW;
    localparam logic [15:0]        LP_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW-1:0] LP_PTR_ONE  = 1;
    localparam logic [FIFO_AW:0]   LP_CNT_ONE  = 1;
    localparam logic [FIFO_AW:0]   LP_CNT_FULL = (FIFO_AW + 1)'(LP_DEPTH);

`ifdef MFP_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic                 r_ap_valid;
    logic                 r_ap_write;
    logic [1:0]           r_ap_addr;
    logic [7:0]           r_mem [0:LP_DEPTH-1];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_ovf;
    state_t               r_state;
    logic [15:0]          r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;
`ifdef MFP_UART_TX_PARITY_EN
    logic                 r_par;
`endif

    logic w_ap_sel;
    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_wr_data;
    logic w_wr_stat;
    logic w_pop;
    logic w_push;
    logic w_unused_ok;

    assign w_ap_sel  = HSEL & HTRANS[1] & HREADY;
    assign w_full    = (r_count == LP_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_active  = (r_state != S_IDLE);
    assign w_wr_data = r_ap_valid & r_ap_write & (r_ap_addr == 2'd0);
    assign w_wr_stat = r_ap_valid & r_ap_write & (r_ap_addr == 2'd1);
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign w_push    = w_wr_data & (~w_full | w_pop);

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign UART_TX     = r_tx;
    assign TX_BUSY     = ~w_empty | w_active;
    assign w_unused_ok = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

    always_comb begin
        HRDATA = 32'd0;
        if (r_ap_valid && !r_ap_write) begin
            case (r_ap_addr)
                2'd1:    HRDATA = {28'd0, r_ovf, w_active, w_empty, w_full};
                2'd2:    HRDATA = 32'(r_count);
                default: HRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= 2'd0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ap_valid <= w_ap_sel;
            if (w_ap_sel) begin
                r_ap_write <= HWRITE;
                r_ap_addr  <= HADDR[3:2];
            end
            if (w_push) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LP_CNT_ONE;
            end
            if (w_wr_data && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && HWDATA[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Line output is registered alongside each state change so bit edges line up with the FSM.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
`ifdef MFP_UART_TX_PARITY_EN
                        r_par   <= ^r_mem[r_rptr];
`endif
                        r_cnt   <= LP_BIT_LAST;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt     <= LP_BIT_LAST;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt <= LP_BIT_LAST;
                        if (r_bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef MFP_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt   <= LP_BIT_LAST;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// tb/tb_mfp_ahb_uart_tx.sv - scoreboard bench for mfp_ahb_uart_tx (CLKS_PER_BIT=4, FIFO_AW=2)
module tb_mfp_ahb_uart_tx;
    localparam int CPB = 4;
    localparam int AW  = 2;
`ifdef MFP_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int G = NB * CPB + 1;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic [1:0]  HTRANS = 2'd0;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = 32'd0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        UART_TX;
    logic        TX_BUSY;

    mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .UART_TX(UART_TX), .TX_BUSY(TX_BUSY)
    );

    always #5 HCLK = ~HCLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  q_exp[$];
    logic [31:0] q_rd[$];
    string       q_rn[$];
    logic        rd_strobe = 1'b0;
    int          ncyc = 0;
    logic        tx_hist   [0:16383];
    logic        busy_hist [0:16383];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge HCLK) ncyc <= ncyc + 1;

    always @(negedge HCLK) begin
        if (ncyc < 16384) begin
            tx_hist[ncyc]   = UART_TX;
            busy_hist[ncyc] = TX_BUSY;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic sel, input logic [1:0] trans);
        @(posedge HCLK); #1;
        HSEL = sel; HTRANS = trans; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        ahb_write(addr, data, 1'b1, 2'b10);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        q_rd.push_back(exp);
        q_rn.push_back(name);
        rd_strobe = 1'b1;
        @(posedge HCLK); #1;
        rd_strobe = 1'b0;
    endtask

    // Expected line level per cycle for one frame plus the following idle cycle.
    task automatic check_wave(input string name, input int t0, input logic [7:0] b);
        int  bad;
        logic e;
        bad = 0;
        for (int r = 0; r < NB * CPB + 1; r++) begin
            int j;
            j = r / CPB;
            if (j == 0)                 e = 1'b0;
            else if (j <= 8)            e = b[j-1];
            else if (NB == 11 && j == 9) e = ^b;
            else                        e = 1'b1;
            if (tx_hist[t0 + r] !== e) bad++;
        end
        check(name, bad, 0);
    endtask

    always @(negedge HCLK) begin
        if (rd_strobe) begin
            if (q_rd.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_queue: got empty expected entry");
            end else begin
                check(q_rn.pop_front(), HRDATA, q_rd.pop_front());
                check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
                check("hresp", {31'd0, HRESP}, 32'd0);
            end
        end
    end

    task automatic wait_n(input int n, inout bit ab);
        repeat (n) begin
            @(negedge HCLK);
            if (HRESETn !== 1'b1) ab = 1'b1;
        end
    endtask

    // Serial receiver: samples each bit in the middle of its CPB-cycle cell.
    initial begin
        logic [7:0] b;
        logic       s0, sp, pb;
        bit         ab;
        forever begin
            @(negedge HCLK);
            if (HRESETn === 1'b1 && UART_TX === 1'b0) begin
                ab = 1'b0;
                wait_n(2, ab);
                s0 = UART_TX;
                for (int i = 0; i < 8; i++) begin
                    wait_n(CPB, ab);
                    b[i] = UART_TX;
                end
                pb = 1'b0;
                if (NB == 11) begin
                    wait_n(CPB, ab);
                    pb = UART_TX;
                end
                wait_n(CPB, ab);
                sp = UART_TX;
                if (!ab) begin
                    if (q_exp.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rx_unexpected: got frame 0x%02h expected none", b);
                    end else begin
                        check("rx_byte", {24'd0, b}, {24'd0, q_exp.pop_front()});
                        check("rx_start", {31'd0, s0}, 32'd0);
                        check("rx_stop", {31'd0, sp}, 32'd1);
                        if (NB == 11) check("rx_parity", {31'd0, pb}, {31'd0, ^b});
                    end
                end
            end
        end
    end

    initial begin
        int t0, t1, t2, zeros;
        logic [7:0] bytes3 [0:2];
        bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;

        idle(3);
        check("reset_tx", {31'd0, UART_TX}, 32'd1);
        check("reset_busy", {31'd0, TX_BUSY}, 32'd0);
        HRESETn = 1'b1;
        rd(32'h4, 32'h2, "reset_status");
        rd(32'h8, 32'h0, "reset_count");
        rd(32'hC, 32'h0, "read_reserved");
        rd(32'h0, 32'h0, "read_txdata");

        ahb_write(32'h0, 32'h77, 1'b0, 2'b10);
        ahb_write(32'h0, 32'h66, 1'b1, 2'b00);
        rd(32'h8, 32'h0, "unselected_count");
        rd(32'h4, 32'h2, "unselected_status");

        q_exp.push_back(8'hA5);
        wr(32'h0, 32'hA5);
        t0 = ncyc + 2;
        idle(G + 8);
        check("fall_latency_pre", {31'd0, tx_hist[t0-1]}, 32'd1);
        check_wave("wave_a5", t0, 8'hA5);

        for (int i = 0; i < 3; i++) q_exp.push_back(bytes3[i]);
        wr(32'h0, 32'h11);
        t1 = ncyc + 2;
        wr(32'h0, 32'h22);
        wr(32'h0, 32'h33);
        idle(3 * G + 10);
        for (int i = 0; i < 3; i++) check_wave($sformatf("wave_b2b%0d", i), t1 + i * G, bytes3[i]);
        check("busy_last_stop", {31'd0, busy_hist[t1 + 2*G + NB*CPB - 1]}, 32'd1);
        check("busy_after_stop", {31'd0, busy_hist[t1 + 2*G + NB*CPB]}, 32'd0);

        q_exp.push_back(8'h5A);
        wr(32'h0, 32'h5A);
        idle(3);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) q_exp.push_back(8'(i));
            wr(32'h0, 32'(i));
        end
        rd(32'h8, 32'h4, "ovf_count");
        rd(32'h4, 32'hD, "ovf_status");
        wr(32'h4, 32'h8);
        rd(32'h4, 32'h5, "ovf_cleared");
        idle(5 * G + 20);
        rd(32'h4, 32'h2, "drained_status");

        wr(32'h0, 32'hC3);
        t2 = ncyc;
        wr(32'h0, 32'h3C);
        wr(32'h0, 32'h81);
        idle(t2 + 18 - ncyc);
        check("mid_frame_active", {31'd0, TX_BUSY}, 32'd1);
        HRESETn = 1'b0;
        q_exp.delete();
        idle(1);
        check("abort_tx", {31'd0, UART_TX}, 32'd1);
        check("abort_busy", {31'd0, TX_BUSY}, 32'd0);
        idle(1);
        HRESETn = 1'b1;
        t2 = ncyc;
        rd(32'h8, 32'h0, "abort_count");
        rd(32'h4, 32'h2, "abort_status");
        idle(3 * G);
        zeros = 0;
        for (int c = t2; c < ncyc; c++) if (tx_hist[c] !== 1'b1) zeros++;
        check("no_frame_after_reset", zeros, 0);

        check("exp_queue_drained", q_exp.size(), 0);
        check("rd_queue_drained", q_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mfp_ahb_uart_tx.md
MFP_AHB_UART_TX -- requirements
Module: mfp_ahb_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, HCLK cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_AW, default 4, TX FIFO address width (depth 2**FIFO_AW).
REQ-003 HCLK  in  1  system clock; all logic on rising edge.
REQ-004 HRESETn  in  1  reset; synchronous and active-low.
REQ-005 HSEL  in  1  slave select from AHB-Lite decoder.
REQ-006 HADDR  in  32  byte address; only HADDR[3:2] decoded.
REQ-007 HTRANS  in  2  transfer type; HTRANS[1]=1 marks NONSEQ/SEQ.
REQ-008 HWRITE  in  1  1=write, 0=read.
REQ-009 HREADY  in  1  bus ready, qualifies the address phase.
REQ-010 HWDATA  in  32  write data, valid in the data phase.
REQ-011 HRDATA  out  32  read data, valid in the data phase.
REQ-012 HREADYOUT  out  1  slave ready; constant 1 (zero wait states).
REQ-013 HRESP  out  1  constant 0 (OKAY).
REQ-014 UART_TX  out  1  serial output; idle high.
REQ-015 TX_BUSY  out  1  1 while the FIFO is non-empty or a frame is in progress.

Function
REQ-016 The address phase SHALL be captured when HSEL & HTRANS[1] & HREADY; HADDR[3:2] and HWRITE are registered; the access executes in the following (data) cycle.
REQ-017 Register map: 0x0 TXDATA (W: push HWDATA[7:0]; R: 0); 0x4 STATUS (R); 0x8 COUNT (R: FIFO occupancy, zero-extended); 0xC reserved (R: 0, W: ignored).
REQ-018 STATUS bits: [0] full, [1] empty, [2] shifter active, [3] sticky overflow; all other bits 0.
REQ-019 Writing STATUS with HWDATA[3]=1 SHALL clear overflow; other STATUS write bits are ignored.
REQ-020 A TXDATA write to a full FIFO SHALL be dropped and set overflow in the same cycle, unless a pop occurs in that cycle, in which case the write SHALL be accepted.
REQ-021 The FIFO SHALL be first-in first-out; pointers wrap modulo 2**FIFO_AW; occupancy is FIFO_AW+1 bits wide.
REQ-022 HRDATA SHALL be driven combinationally from registered data-phase state; reads have no side effects.
REQ-023 Transmitter FSM states: IDLE, START, DATA, [PARITY], STOP.
REQ-024 IDLE: UART_TX=1; when the FIFO is non-empty, pop one byte into the shifter and enter START on the next edge.
REQ-025 START drives 0; DATA drives bits 0..7, LSB first; STOP drives 1; each bit lasts exactly CLKS_PER_BIT cycles, timed by a 16-bit down-counter.
REQ-026 At the end of STOP the FSM SHALL return to IDLE; a non-empty FIFO SHALL then be popped in that IDLE cycle, so the inter-frame gap is 1 cycle.
REQ-027 UART_TX SHALL fall 2 cycles after the data-phase cycle of a TXDATA write into an empty, idle transmitter.
REQ-028 UART_TX SHALL be driven from a flop (glitch-free).

Reset
REQ-029 While HRESETn=0 at a clock edge: FIFO emptied, pointers 0, overflow 0, FSM IDLE, bit counter 0, UART_TX=1, TX_BUSY=0, registered address-phase state cleared (no pending access).
REQ-030 A reset asserted mid-frame SHALL abort the frame; UART_TX SHALL be 1 from the first edge with HRESETn=0, and the pending bytes SHALL be discarded.

Configuration
REQ-031 Macro MFP_UART_TX_PARITY_EN: when defined, a PARITY state SHALL follow DATA, driving the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; the frame is then 11 bits.
REQ-032 Without MFP_UART_TX_PARITY_EN: no PARITY state exists; DATA is followed directly by STOP; the frame is 10 bits.

Verification
REQ-033 CLKS_PER_BIT=4, write 0xA5 to 0x0 -> UART_TX: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; with the parity macro, a parity bit 0 precedes the stop bit.
REQ-034 Write 0x11,0x22,0x33 back-to-back -> three frames in order, 1-cycle idle gap between frames, TX_BUSY falls one cycle after the last stop bit.
REQ-035 FIFO_AW=2, shifter busy, write 6 bytes -> COUNT=4, STATUS[0]=1, STATUS[3]=1; write 0x8 to 0x4 -> STATUS[3]=0.
REQ-036 Read 0x4 after reset -> HRDATA=0x00000002; read 0xC -> 0; HREADYOUT=1 and HRESP=0 throughout.
REQ-037 Assert HRESETn=0 during bit 3 of a frame with 2 bytes queued -> UART_TX=1 from the next edge, COUNT=0, and no further frames after reset release.
REQ-038 HSEL=1 with HTRANS=IDLE, or HSEL=0, on a write -> no FIFO push, COUNT unchanged.
